instr_mem_loader: RTL

- Writer side of the byte-addressed instruction ROM.
- Accepts 32-bit instruction words over a valid/ready stream and writes each word as four byte writes into the instruction byte array.
- Byte order is little-endian: byte k of the word goes to address base+k, which matches the ROM's read-side assembly.
- Sits between a boot/debug source (UART bridge or testbench) and the instruction memory write port. Holds the core stalled while loading.

---
 rtl/instr_mem_pkg.sv | 27 ++
 rtl/loader_byte_sequencer.sv | 67 ++++++
 rtl/instr_mem_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory loader.
//   loader_state_t : FSM states of the loader
//   INSTR_BYTES    : bytes per instruction word
//   LANE_W         : width of a byte-lane index within a word
//   lane_byte()    : little-endian byte-lane extraction
package instr_mem_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned LANE_W      = $clog2(INSTR_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_WORD,
    ST_WR_B0,
    ST_WR_B1,
    ST_WR_B2,
    ST_WR_B3,
    ST_FINISH
  } loader_state_t;

  // Lane k is bits [8k+7:8k]; lane 0 lands at the lowest address.
  function automatic logic [7:0] lane_byte(input logic [31:0] word,
                                           input logic [LANE_W-1:0] lane);
    return word[8*lane +: 8];
  endfunction

endpackage

// File: rtl/loader_byte_sequencer.sv
// Datapath of the instruction loader: word register, byte-lane mux and the
// write pointer with wrap detection. All memory-side outputs are registered.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   load        : latch base_addr into the pointer, clear wrapped
//   base_addr   : first byte address of a burst
//   capture     : store in_data into the word register
//   emit        : launch one byte write (register addr/data, bump pointer)
//   lane        : byte lane to emit
//   in_data     : incoming instruction word
//   mem_addr    : registered write address
//   mem_wdata   : registered write byte
//   wrapped     : sticky, pointer rolled over from all-ones to zero
module loader_byte_sequencer
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic                     capture,
  input  logic                     emit,
  input  logic [LANE_W-1:0]        lane,
  input  logic [31:0]              in_data,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     wrapped
);

  logic [31:0]              word;
  logic [31:0]              src;
  logic [ADDRESS_WIDTH-1:0] ptr;

  // Lane 0 is emitted in the same cycle the word is accepted, before the
  // word register holds it, so it is taken straight from in_data.
  always_comb begin
    src = capture ? in_data : word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word      <= '0;
      ptr       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wrapped   <= 1'b0;
    end else begin
      if (capture) begin
        word <= in_data;
      end
      if (load) begin
        ptr     <= base_addr;
        wrapped <= 1'b0;
      end else if (emit) begin
        ptr       <= ptr + 1'b1;
        mem_addr  <= ptr;
        mem_wdata <= lane_byte(src, lane);
        if (&ptr) begin
          wrapped <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Writer side of the byte-addressed instruction ROM. Accepts 32-bit words on
// a valid/ready stream and writes each as four little-endian byte writes.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : one-cycle pulse, begin a burst (ignored while busy)
//   base_addr   : first byte address of the burst
//   word_count  : number of 32-bit words in the burst
//   in_valid    : in_data valid
//   in_data     : instruction word
//   in_ready    : word accepted this cycle when in_valid is also high
//   mem_we      : byte write strobe
//   mem_addr    : byte write address
//   mem_wdata   : byte write data
//   busy        : burst in progress (core stall)
//   done        : one-cycle pulse at burst completion
//   wrapped     : sticky address wrap flag for the current/last burst
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-2:0] word_count,
  input  logic                     in_valid,
  input  logic [31:0]              in_data,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     wrapped
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("instr_mem_loader: DATA_WIDTH must be 8");
  end

  loader_state_t            state, state_next;
  logic [ADDRESS_WIDTH-2:0] remaining;
  logic                     load, capture, emit;
  logic [LANE_W-1:0]        lane;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    emit       = 1'b0;
    lane       = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = (word_count == '0) ? ST_FINISH : ST_WAIT_WORD;
        end
      end
      ST_WAIT_WORD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          emit       = 1'b1;
          lane       = LANE_W'(0);
          state_next = ST_WR_B0;
        end
      end
      // Each WR state shows one byte on the bus while the next is launched.
      ST_WR_B0: begin
        emit       = 1'b1;
        lane       = LANE_W'(1);
        state_next = ST_WR_B1;
      end
      ST_WR_B1: begin
        emit       = 1'b1;
        lane       = LANE_W'(2);
        state_next = ST_WR_B2;
      end
      ST_WR_B2: begin
        emit       = 1'b1;
        lane       = LANE_W'(3);
        state_next = ST_WR_B3;
      end
      ST_WR_B3: begin
        state_next = (remaining == (ADDRESS_WIDTH-1)'(1)) ? ST_FINISH : ST_WAIT_WORD;
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        remaining <= word_count;
      end else if (state == ST_WR_B3) begin
        remaining <= remaining - 1'b1;
      end
      // Registered from the upcoming state so they align with the WR states.
      mem_we <= emit;
      busy   <= (state_next != ST_IDLE);
      done   <= (state_next == ST_FINISH);
    end
  end

  loader_byte_sequencer #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .base_addr (base_addr),
    .capture   (capture),
    .emit      (emit),
    .lane      (lane),
    .in_data   (in_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .wrapped   (wrapped)
  );

endmodule
